// File: rtl/sdu_pkg.sv
// Shared constants and FSM state type for the FFT spectrum capture block.
package sdu_pkg;
  localparam int N_BINS = 128;
  localparam int DW     = 32;
  localparam int PW     = 2 * DW;

  typedef enum logic [2:0] {
    S_IDLE, S_UNLOAD, S_WAIT_DV, S_CAPTURE, S_DRAIN, S_READY
  } state_e;
endpackage

// File: rtl/fft_spectrum_capture_cplx_power.sv
// Two-stage |z|^2 pipeline: squares registered, then the unsigned sum registered.
module cplx_power #(
  parameter int DW = 32,
  parameter int TW = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_vld,
  input  logic [TW-1:0]        i_tag,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic                 o_vld,
  output logic [TW-1:0]        o_tag,
  output logic [2*DW-1:0]      o_pwr
);
  localparam int STAGES = 2;

  logic [STAGES:1]           vld_pipe;
  logic [STAGES:1][TW-1:0]   r_tag;
  logic signed [2*DW-1:0]    r_sq_re, r_sq_im;
  logic [2*DW-1:0]           r_pwr;
  logic signed [2*DW-1:0]    w_re_x, w_im_x;

  assign w_re_x = {{DW{i_re[DW-1]}}, i_re};
  assign w_im_x = {{DW{i_im[DW-1]}}, i_im};

  // Each square is at most 2^(2*DW-2), so the sum always fits unsigned in 2*DW bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      r_tag    <= '0;
      r_sq_re  <= '0;
      r_sq_im  <= '0;
      r_pwr    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], i_vld};
      r_tag    <= {r_tag[1], i_tag};
      r_sq_re  <= w_re_x * w_re_x;
      r_sq_im  <= w_im_x * w_im_x;
      r_pwr    <= $unsigned(r_sq_re) + $unsigned(r_sq_im);
    end
  end

  assign o_vld = vld_pipe[STAGES];
  assign o_tag = r_tag[STAGES];
  assign o_pwr = r_pwr;
endmodule

// File: rtl/fft_spectrum_capture.sv
// Unloads one FFT frame, converts bins to power and stores them fftshifted for readout.
module fft_spectrum_capture #(
  parameter int N_BINS     = sdu_pkg::N_BINS,
  parameter int DW         = sdu_pkg::DW,
  parameter int DV_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fft_done,
  output logic                      fft_unload,
  input  logic                      fft_dv,
  input  logic signed [DW-1:0]      dout_re,
  input  logic signed [DW-1:0]      dout_im,
  output logic                      frame_ready,
  input  logic                      frame_ack,
  input  logic                      rd_en,
  input  logic [$clog2(N_BINS)-1:0] rd_addr,
  output logic [2*DW-1:0]           rd_data,
  output logic                      busy,
  output logic                      short_frame,
  output logic                      timeout_err
);
  import sdu_pkg::*;

  localparam int AW  = $clog2(N_BINS);
  localparam int PWL = 2 * DW;
  localparam int CW  = $clog2(DV_TIMEOUT) + 1;

  state_e          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_bin;
  logic            r_short_cur;
  logic            w_cap, w_last, w_tmo, w_drop;
  logic            w_pwr_vld;
  logic [AW-1:0]   w_pwr_tag, w_waddr;
  logic [PWL-1:0]  w_pwr;
  logic [PWL-1:0]  r_mem [N_BINS];

  assign w_cap  = ((r_state == S_WAIT_DV) || (r_state == S_CAPTURE)) && fft_dv;
  assign w_last = w_cap && (r_bin == AW'(N_BINS - 1));
  assign w_tmo  = (r_state == S_WAIT_DV) && !fft_dv && (r_cnt == CW'(DV_TIMEOUT - 1));
  assign w_drop = (r_state == S_CAPTURE) && !fft_dv;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (fft_done) w_next = S_UNLOAD;
      S_UNLOAD:  w_next = S_WAIT_DV;
      S_WAIT_DV: begin
        if (w_last)      w_next = S_DRAIN;
        else if (fft_dv) w_next = S_CAPTURE;
        else if (w_tmo)  w_next = S_IDLE;
      end
      S_CAPTURE: if (w_last || w_drop) w_next = S_DRAIN;
      S_DRAIN:   if (r_cnt == CW'(1)) w_next = r_short_cur ? S_IDLE : S_READY;
      S_READY:   if (frame_ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign fft_unload  = (r_state == S_UNLOAD);
  assign frame_ready = (r_state == S_READY);
  assign busy        = (r_state != S_IDLE);

  // r_cnt restarts on every state change, so WAIT_DV and DRAIN both see it from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bin       <= '0;
      r_short_cur <= 1'b0;
      short_frame <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state != w_next) ? '0 : r_cnt + 1'b1;
      if (r_state == S_UNLOAD) begin
        r_bin       <= '0;
        r_short_cur <= 1'b0;
      end else if (w_cap) begin
        r_bin <= r_bin + 1'b1;
      end
      if (w_drop) begin
        r_short_cur <= 1'b1;
        short_frame <= 1'b1;
      end
      if (w_tmo) timeout_err <= 1'b1;
    end
  end

  cplx_power #(.DW(DW), .TW(AW)) u_pwr (
    .clk   (clk),
    .reset (reset),
    .i_vld (w_cap),
    .i_tag (r_bin),
    .i_re  (dout_re),
    .i_im  (dout_im),
    .o_vld (w_pwr_vld),
    .o_tag (w_pwr_tag),
    .o_pwr (w_pwr)
  );

  // fftshift: flipping the MSB puts DC in the middle of the buffer.
  assign w_waddr = w_pwr_tag ^ AW'(N_BINS / 2);

  always_ff @(posedge clk) begin
    if (w_pwr_vld) r_mem[w_waddr] <= w_pwr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= r_mem[rd_addr];
  end
endmodule

// File: tb/tb_fft_spectrum_capture.sv
// Randomized frames checked against a bin-power model of the fftshifted buffer.
module tb_fft_spectrum_capture;
  localparam int NB  = 128;
  localparam int TMO = 1024;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               fft_done = 1'b0, fft_dv = 1'b0, frame_ack = 1'b0, rd_en = 1'b0;
  logic signed [31:0] dout_re = '0, dout_im = '0;
  logic [6:0]         rd_addr = '0;
  logic               fft_unload, frame_ready, busy, short_frame, timeout_err;
  logic [63:0]        rd_data;

  int checks = 0, errors = 0;
  logic               started = 1'b0;
  logic [63:0]        model_mem [NB];
  logic [63:0]        exp_rd = '0;
  logic               m_short = 1'b0, m_to = 1'b0;
  logic signed [31:0] fre [NB], fim [NB];

  fft_spectrum_capture #(.N_BINS(NB), .DW(32), .DV_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .fft_done(fft_done), .fft_unload(fft_unload),
    .fft_dv(fft_dv), .dout_re(dout_re), .dout_im(dout_im), .frame_ready(frame_ready),
    .frame_ack(frame_ack), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .short_frame(short_frame), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pwr(logic signed [31:0] re, logic signed [31:0] im);
    longint r = re, i = im;
    logic [63:0] ar = (r < 0) ? 64'(-r) : 64'(r);
    logic [63:0] ai = (i < 0) ? 64'(-i) : 64'(i);
    return ar * ar + ai * ai;
  endfunction

  // Read model: the registered read port shows the stored power one edge after rd_en.
  always @(posedge clk or posedge reset) begin
    if (reset)      exp_rd <= '0;
    else if (rd_en) exp_rd <= model_mem[rd_addr];
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("rd_data", rd_data, exp_rd);
      chk("short_frame", {63'b0, short_frame}, {63'b0, m_short});
      chk("timeout_err", {63'b0, timeout_err}, {63'b0, m_to});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(int nb, int gap, bit in_unload);
    if (!in_unload) begin
      fft_done = 1'b1;
      tick();
      chk("unload_pulse", {63'b0, fft_unload}, 64'd1);
    end
    fft_done = 1'b0;
    tick();
    chk("unload_once", {63'b0, fft_unload}, 64'd0);
    chk("busy_wait", {63'b0, busy}, 64'd1);
    repeat (gap) tick();
    for (int k = 0; k < nb; k++) begin
      fft_dv = 1'b1; dout_re = fre[k]; dout_im = fim[k];
      model_mem[k ^ (NB / 2)] = pwr(fre[k], fim[k]);
      tick();
    end
    fft_dv = 1'b0; dout_re = $urandom; dout_im = $urandom;
    if (nb < NB) begin
      tick();
      m_short = 1'b1;
      tick();
      chk("busy_drain", {63'b0, busy}, 64'd1);
      tick();
      chk("short_idle", {63'b0, busy}, 64'd0);
      chk("short_noready", {63'b0, frame_ready}, 64'd0);
    end else begin
      tick();
      chk("drain_noready", {63'b0, frame_ready}, 64'd0);
      tick();
      chk("ready", {63'b0, frame_ready}, 64'd1);
    end
  endtask

  task automatic read_one(int a, output logic [63:0] d);
    rd_en = 1'b1; rd_addr = 7'(a);
    tick();
    rd_en = 1'b0; rd_addr = 7'($urandom);
    d = rd_data;
  endtask

  task automatic ack;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("ack_noready", {63'b0, frame_ready}, 64'd0);
    chk("ack_idle", {63'b0, busy}, 64'd0);
  endtask

  task automatic rand_data;
    for (int k = 0; k < NB; k++) begin fre[k] = $urandom; fim[k] = $urandom; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_unload", {63'b0, fft_unload}, 64'd0);
    chk("rst_ready", {63'b0, frame_ready}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    reset = 1'b0;
    started = 1'b1;
    tick();

    // Impulse frame, then READY ignores fft_done and re-arms right after the ack.
    for (int k = 0; k < NB; k++) begin fre[k] = 32; fim[k] = 0; end
    run_frame(NB, 3, 1'b0);
    for (int a = 0; a < NB; a++) begin read_one(a, d); chk("impulse", d, 64'd1024); end
    fft_done = 1'b1;
    tick(); tick();
    chk("ready_hold", {63'b0, frame_ready}, 64'd1);
    chk("ready_no_unload", {63'b0, fft_unload}, 64'd0);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("ack_release", {63'b0, frame_ready}, 64'd0);
    chk("idle_no_unload", {63'b0, fft_unload}, 64'd0);
    tick();
    chk("rearm_unload", {63'b0, fft_unload}, 64'd1);

    for (int k = 0; k < NB; k++) begin fre[k] = k; fim[k] = 0; end
    run_frame(NB, 2, 1'b1);
    read_one(64, d);  chk("order_dc", d, 64'd0);
    read_one(0, d);   chk("order_a0", d, 64'd4096);
    read_one(127, d); chk("order_a127", d, 64'd3969);
    ack();

    for (int k = 0; k < NB; k++) begin fre[k] = 32'sh8000_0000; fim[k] = 32'sh8000_0000; end
    run_frame(NB, 0, 1'b0);
    read_one(64, d); chk("extreme", d, 64'h8000_0000_0000_0000);
    read_one(3, d);  chk("extreme2", d, 64'h8000_0000_0000_0000);
    ack();

    for (int f = 0; f < 3; f++) begin
      rand_data();
      run_frame(NB, $urandom_range(0, 5), 1'b0);
      repeat (20) begin read_one($urandom_range(0, NB - 1), d); repeat ($urandom_range(0, 2)) tick(); end
      ack();
    end

    rand_data();
    run_frame(100, 1, 1'b0);
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
    chk("ack_outside", {63'b0, busy}, 64'd0);

    fft_done = 1'b1; tick(); fft_done = 1'b0; tick();
    repeat (TMO - 1) tick();
    chk("tmo_busy", {63'b0, busy}, 64'd1);
    tick();
    m_to = 1'b1;
    chk("tmo_idle", {63'b0, busy}, 64'd0);
    tick();

    rand_data();
    run_frame(NB, 4, 1'b0);
    for (int a = 0; a < NB; a += 7) read_one(a, d);
    ack();

    rand_data();
    fft_done = 1'b1; tick(); fft_done = 1'b0; tick();
    for (int k = 0; k < 50; k++) begin fft_dv = 1'b1; dout_re = fre[k]; dout_im = fim[k]; tick(); end
    reset = 1'b1; m_short = 1'b0; m_to = 1'b0;
    #1;
    chk("mid_rst_unload", {63'b0, fft_unload}, 64'd0);
    chk("mid_rst_ready", {63'b0, frame_ready}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_short", {63'b0, short_frame}, 64'd0);
    chk("mid_rst_tmo", {63'b0, timeout_err}, 64'd0);
    chk("mid_rst_rd", rd_data, 64'd0);
    fft_dv = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    rand_data();
    run_frame(NB, 1, 1'b0);
    for (int a = 0; a < NB; a++) read_one(a, d);
    ack();

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_spectrum_capture.md
FFT_SPECTRUM_CAPTURE -- requirements
Module: fft_spectrum_capture

Interface
REQ-001 Parameters (name, default, meaning): N_BINS, 128, bins per FFT frame (power of 2); DW, 32, FFT output component width; DV_TIMEOUT, 1024, cycles allowed between unload pulse and first fft_dv.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fft_done  input  1  FFT frame complete, level, from FFT core.
REQ-005 fft_unload  output  1  one-cycle unload request to FFT core.
REQ-006 fft_dv  input  1  FFT output data valid, one bin per cycle.
REQ-007 dout_re, dout_im  input  DW each  signed FFT bin, natural bin order.
REQ-008 frame_ready  output  1  captured power spectrum available for readout.
REQ-009 frame_ack  input  1  consumer releases buffer; pulse.
REQ-010 rd_en  input  1  buffer read strobe.
REQ-011 rd_addr  input  log2(N_BINS)  display-order read address.
REQ-012 rd_data  output  2*DW  unsigned bin power, registered.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 short_frame, timeout_err  output  1 each  sticky error flags.

Function
REQ-015 FSM states: IDLE, UNLOAD, WAIT_DV, CAPTURE, DRAIN, READY.
REQ-016 IDLE -> UNLOAD when fft_done=1; UNLOAD lasts exactly one cycle, fft_unload=1 only in UNLOAD.
REQ-017 WAIT_DV: cycle counter from 0; fft_dv=1 -> CAPTURE (that cycle's bin captured as bin 0); counter reaching DV_TIMEOUT-1 -> IDLE, set timeout_err.
REQ-018 CAPTURE: each fft_dv=1 cycle takes next bin, index 0..N_BINS-1; after bin N_BINS-1 -> DRAIN.
REQ-019 fft_dv falling before N_BINS bins -> set short_frame, discard frame, go to DRAIN then IDLE (frame_ready stays 0).
REQ-020 Power = re*re + im*im, signed squares, unsigned sum, full 2*DW width; -2^(DW-1) squared included, no saturation needed for DW<=32 since sum < 2^(2*DW).
REQ-021 Power pipeline latency exactly 2 cycles (register squares, register sum); bin index delayed alongside.
REQ-022 Write address = bin index XOR N_BINS/2 (fftshift: DC at address N_BINS/2, most-negative frequency at 0).
REQ-023 DRAIN waits 2 cycles for pipeline to empty, then -> READY (full frame) or IDLE (short frame).
REQ-024 READY: frame_ready=1; fft_done ignored; frame_ack=1 -> IDLE next cycle, frame_ready=0 same edge.
REQ-025 frame_ack outside READY ignored; fft_dv outside WAIT_DV/CAPTURE ignored.
REQ-026 Read port: rd_data <= buf[rd_addr] one cycle after rd_en=1; rd_data holds when rd_en=0; reads legal in any state, returning the last stored content.
REQ-027 Error flags cleared only by reset; a new frame may proceed with flags set.
REQ-028 fft_done held high across READY->IDLE starts new unload immediately (IDLE->UNLOAD next cycle).

Reset
REQ-029 Reset returns FSM to IDLE, fft_unload=0, frame_ready=0, busy=0, short_frame=0, timeout_err=0, rd_data=0, counters and pipeline valid bits 0.
REQ-030 Buffer contents are not reset; reset mid-CAPTURE abandons the frame with no further writes.

Structure
REQ-031 Shared package sdu_pkg holds N_BINS, DW, state enum type and power-width constant.
REQ-032 One sub-module cplx_power: 2-stage |z|^2 pipeline with valid and tag passthrough.
REQ-033 Buffer is a single N_BINS x 2*DW synchronous RAM, one write and one read port.

Verification
REQ-034 Impulse: 128 bins all re=32, im=0 -> fft_unload one pulse after fft_done, frame_ready, every rd_data=1024.
REQ-035 Ordering: bin k re=k, im=0 -> rd_addr 64 returns 0, rd_addr 0 returns 4096 (bin 64), rd_addr 127 returns 3969 (bin 63).
REQ-036 Extremes: re=-2^31, im=-2^31 -> rd_data=2^63 at shifted address.
REQ-037 Short frame: fft_dv drops after 100 bins -> short_frame=1, frame_ready stays 0, FSM IDLE.
REQ-038 Timeout: fft_done with no fft_dv -> IDLE after DV_TIMEOUT cycles, timeout_err=1, busy=0.
REQ-039 Reset asserted at bin 50 -> all outputs at reset values immediately; next full frame captures correctly.
